// File: rtl/compute_arbiter.sv
// rtl/compute_arbiter.sv - round-robin arbiter sharing one compute unit among four requesters
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   req_i, req_type_i   per-unit request level (held until done_o) and operation type
//   grant_o             one-hot grant, also the external operand-mux select
//   done_o              one-hot, one-cycle completion pulse to the granted unit
//   timeout_o           pulses with done_o when the compute unit never answered
//   busy_o              high whenever the FSM is not IDLE
//   cu_unit_id          winner ID presented to the shared compute unit
//   cu_request          one-cycle start pulse to the shared compute unit
//   cu_comp_type        latched operation type of the winner
//   cu_ready, cu_done   compute unit idle / completion indications

package compute_arbiter_pkg;
  typedef logic [1:0] computation_type_t;
endpackage

module compute_arbiter
  import compute_arbiter_pkg::*;
#(
  parameter int NUM_UNITS      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic              [NUM_UNITS-1:0]    req_i,
  input  computation_type_t [NUM_UNITS-1:0]    req_type_i,
  output logic              [NUM_UNITS-1:0]    grant_o,
  output logic              [NUM_UNITS-1:0]    done_o,
  output logic                                 timeout_o,
  output logic                                 busy_o,
  output logic              [1:0]              cu_unit_id,
  output logic                                 cu_request,
  output computation_type_t                    cu_comp_type,
  input  logic                                 cu_ready,
  input  logic                                 cu_done
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_UNITS-1:0] UNIT0 = NUM_UNITS'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [1:0]        winner_q, winner_d;
  logic [NUM_UNITS-1:0] grant_q, grant_d;
  computation_type_t comp_type_q, comp_type_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tmo_q, tmo_d;

  logic [1:0]        arb_win;
  logic [1:0]        arb_idx;

  // Round-robin search upward from rr_ptr+1. Walking the offsets from the
  // far end downward lets the nearest requester overwrite any farther one.
  always_comb begin
    arb_win = 2'd0;
    arb_idx = 2'd0;
    for (int i = NUM_UNITS; i >= 1; i--) begin
      arb_idx = rr_ptr_q + 2'(i);
      if (req_i[arb_idx]) begin
        arb_win = arb_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    winner_d    = winner_q;
    grant_d     = grant_q;
    comp_type_d = comp_type_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    case (state_q)
      IDLE: begin
        if (|req_i && cu_ready) begin
          state_d     = ISSUE;
          winner_d    = arb_win;
          grant_d     = UNIT0 << arb_win;
          comp_type_d = req_type_i[arb_win];
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        tmo_d   = 1'b0;
        state_d = WAIT;
      end
      WAIT: begin
        // A completion in the final counted cycle still beats the timeout.
        if (cu_done) begin
          state_d = RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASE;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        grant_d  = '0;
        rr_ptr_d = winner_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 2'd3;
      winner_q    <= 2'd0;
      grant_q     <= '0;
      comp_type_q <= '0;
      cnt_q       <= '0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      winner_q    <= winner_d;
      grant_q     <= grant_d;
      comp_type_q <= comp_type_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
    end
  end

  assign grant_o      = grant_q;
  assign done_o       = (state_q == RELEASE) ? (UNIT0 << winner_q) : '0;
  assign timeout_o    = (state_q == RELEASE) && tmo_q;
  assign busy_o       = (state_q != IDLE);
  assign cu_unit_id   = winner_q;
  assign cu_request   = (state_q == ISSUE);
  assign cu_comp_type = comp_type_q;

endmodule

// File: tb/tb_compute_arbiter.sv
// tb/tb_compute_arbiter.sv - self-checking bench for compute_arbiter
module tb_compute_arbiter;
  import compute_arbiter_pkg::*;

  localparam logic [7:0] T_A = 8'h1B;  // u0=3 u1=2 u2=1 u3=0
  localparam logic [7:0] T_B = 8'hB1;  // u0=1 u1=0 u2=3 u3=2

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        req_i;
  computation_type_t [3:0] req_type_i;
  logic [3:0]        grant_o;
  logic [3:0]        done_o;
  logic              timeout_o;
  logic              busy_o;
  logic [1:0]        cu_unit_id;
  logic              cu_request;
  computation_type_t cu_comp_type;
  logic              cu_ready;
  logic              cu_done;

  always #5 clk = ~clk;

  compute_arbiter #(.NUM_UNITS(4), .TIMEOUT_CYCLES(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .req_type_i   (req_type_i),
    .grant_o      (grant_o),
    .done_o       (done_o),
    .timeout_o    (timeout_o),
    .busy_o       (busy_o),
    .cu_unit_id   (cu_unit_id),
    .cu_request   (cu_request),
    .cu_comp_type (cu_comp_type),
    .cu_ready     (cu_ready),
    .cu_done      (cu_done)
  );

  typedef struct {
    logic [3:0] req;
    logic       ready;
    logic [7:0] types;
    logic [3:0] exp_grant;
    logic [1:0] exp_id;
    logic [1:0] exp_type;
  } vec_t;

  typedef struct {
    logic [3:0] done;
    logic       tmo;
  } done_exp_t;

  done_exp_t done_q[$];
  done_exp_t mon_e;
  int n_vec = 0;
  int n_bad = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic push_done(input logic [3:0] d, input logic t);
    done_exp_t e;
    e.done = d;
    e.tmo  = t;
    done_q.push_back(e);
  endtask

  // Scoreboard side: every done_o pulse must match the oldest expected completion.
  always @(negedge clk) begin
    check("grant_onehot0", 32'($onehot0(grant_o)), 32'd1);
    check("done_onehot0", 32'($onehot0(done_o)), 32'd1);
    if (done_o != 4'b0000) begin
      if (done_q.size() == 0) begin
        check("spurious_done", 32'(done_o), 32'd0);
      end else begin
        mon_e = done_q.pop_front();
        check("done_o", 32'(done_o), 32'(mon_e.done));
        check("timeout_o", 32'(timeout_o), 32'(mon_e.tmo));
      end
    end else begin
      check("timeout_without_done", 32'(timeout_o), 32'd0);
    end
  end

  task automatic check_quiet(input string name);
    check({name, "_grant"}, 32'(grant_o), 32'd0);
    check({name, "_done"}, 32'(done_o), 32'd0);
    check({name, "_timeout"}, 32'(timeout_o), 32'd0);
    check({name, "_busy"}, 32'(busy_o), 32'd0);
    check({name, "_cu_request"}, 32'(cu_request), 32'd0);
    check({name, "_unit_id"}, 32'(cu_unit_id), 32'd0);
    check({name, "_comp_type"}, 32'(cu_comp_type), 32'd0);
  endtask

  task automatic do_reset();
    req_i   = 4'b0000;
    cu_done = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
  endtask

  task automatic wait_issue();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (cu_request) seen = 1'b1;
    end
    check("issue_seen", 32'(cu_request), 32'd1);
  endtask

  // Called in the ISSUE cycle; completes the transaction and returns in IDLE.
  task automatic finish_txn();
    repeat (2) @(negedge clk);
    cu_done = 1'b1;
    @(negedge clk);
    cu_done = 1'b0;
    @(negedge clk);
    check("idle_after_release", 32'(busy_o), 32'd0);
  endtask

  task automatic apply_vec(input vec_t v);
    req_i      = v.req;
    cu_ready   = v.ready;
    req_type_i = v.types;
    @(negedge clk);
    check("vec_grant", 32'(grant_o), 32'(v.exp_grant));
    check("vec_cu_request", 32'(cu_request), 32'(v.exp_grant != 4'b0000));
    if (v.exp_grant != 4'b0000) begin
      check("vec_unit_id", 32'(cu_unit_id), 32'(v.exp_id));
      check("vec_comp_type", 32'(cu_comp_type), 32'(v.exp_type));
      check("vec_busy_issue", 32'(busy_o), 32'd1);
      push_done(v.exp_grant, 1'b0);
      cu_done    = 1'b1;
      req_i      = 4'b0000;
      req_type_i = ~v.types;
      @(negedge clk);
      cu_done = 1'b0;
      check("vec_request_once", 32'(cu_request), 32'd0);
      check("vec_cu_done_ignored_in_issue", 32'(done_o), 32'd0);
      check("vec_grant_hold", 32'(grant_o), 32'(v.exp_grant));
      check("vec_unit_hold", 32'(cu_unit_id), 32'(v.exp_id));
      check("vec_type_hold", 32'(cu_comp_type), 32'(v.exp_type));
      repeat (4) @(negedge clk);
      cu_done = 1'b1;
      @(negedge clk);
      cu_done = 1'b0;
      check("vec_grant_in_release", 32'(grant_o), 32'(v.exp_grant));
      @(negedge clk);
      check("vec_idle_busy", 32'(busy_o), 32'd0);
      check("vec_idle_grant", 32'(grant_o), 32'd0);
      check("vec_done_drained", 32'(done_q.size()), 32'd0);
    end else begin
      cu_done = 1'b1;
      repeat (3) @(negedge clk);
      check("vec_nogrant_busy", 32'(busy_o), 32'd0);
      check("vec_nogrant_grant", 32'(grant_o), 32'd0);
      cu_done  = 1'b0;
      req_i    = 4'b0000;
      cu_ready = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vt[12];
    logic [1:0] rr_order[5];

    rst_n      = 1'b0;
    req_i      = 4'b0000;
    req_type_i = '0;
    cu_ready   = 1'b0;
    cu_done    = 1'b0;

    vt[0]  = '{4'b0100, 1'b1, T_A, 4'b0100, 2'd2, 2'd1};
    vt[1]  = '{4'b1111, 1'b1, T_B, 4'b1000, 2'd3, 2'd2};
    vt[2]  = '{4'b1111, 1'b1, T_A, 4'b0001, 2'd0, 2'd3};
    vt[3]  = '{4'b0011, 1'b1, T_B, 4'b0010, 2'd1, 2'd0};
    vt[4]  = '{4'b0011, 1'b1, T_A, 4'b0001, 2'd0, 2'd3};
    vt[5]  = '{4'b1000, 1'b1, T_B, 4'b1000, 2'd3, 2'd2};
    vt[6]  = '{4'b1000, 1'b1, T_A, 4'b1000, 2'd3, 2'd0};
    vt[7]  = '{4'b0110, 1'b1, T_B, 4'b0010, 2'd1, 2'd0};
    vt[8]  = '{4'b0000, 1'b1, T_A, 4'b0000, 2'd0, 2'd0};
    vt[9]  = '{4'b1111, 1'b0, T_B, 4'b0000, 2'd0, 2'd0};
    vt[10] = '{4'b1101, 1'b1, T_A, 4'b0100, 2'd2, 2'd1};
    vt[11] = '{4'b0101, 1'b1, T_B, 4'b0001, 2'd0, 2'd1};

    rr_order[0] = 2'd0;
    rr_order[1] = 2'd1;
    rr_order[2] = 2'd2;
    rr_order[3] = 2'd3;
    rr_order[4] = 2'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;

    // Compute unit not ready: hold in IDLE, then grant unit 0
    req_i      = 4'b1111;
    req_type_i = T_B;
    repeat (3) @(negedge clk);
    check("not_ready_grant", 32'(grant_o), 32'd0);
    check("not_ready_busy", 32'(busy_o), 32'd0);
    cu_ready = 1'b1;
    wait_issue();
    check("ready_grant", 32'(grant_o), 32'b0001);
    check("ready_comp_type", 32'(cu_comp_type), 32'd1);
    push_done(4'b0001, 1'b0);
    finish_txn();

    // Table of single transactions with a running round-robin pointer
    do_reset();
    for (int i = 0; i < 12; i++) begin
      apply_vec(vt[i]);
    end

    // Continuous requests from all four units rotate 0,1,2,3,0
    do_reset();
    req_i      = 4'b1111;
    req_type_i = T_A;
    for (int k = 0; k < 5; k++) begin
      wait_issue();
      check("rr_unit_id", 32'(cu_unit_id), 32'(rr_order[k]));
      check("rr_grant", 32'(grant_o), 32'(4'b0001 << rr_order[k]));
      push_done(4'(4'b0001 << rr_order[k]), 1'b0);
      finish_txn();
    end

    // Timeout after 64 WAIT cycles
    do_reset();
    req_i      = 4'b0010;
    req_type_i = T_A;
    wait_issue();
    check("tmo_unit_id", 32'(cu_unit_id), 32'd1);
    check("tmo_comp_type", 32'(cu_comp_type), 32'd2);
    push_done(4'b0010, 1'b1);
    req_i = 4'b0000;
    repeat (64) @(negedge clk);
    check("tmo_not_early", 32'(done_o), 32'd0);
    check("tmo_busy_wait", 32'(busy_o), 32'd1);
    @(negedge clk);
    check("tmo_pulse", 32'(timeout_o), 32'd1);
    check("tmo_done", 32'(done_o), 32'b0010);
    @(negedge clk);
    check("tmo_idle", 32'(busy_o), 32'd0);

    // cu_done in the last counted WAIT cycle wins over the timeout
    req_i = 4'b0001;
    wait_issue();
    check("race_unit_id", 32'(cu_unit_id), 32'd0);
    push_done(4'b0001, 1'b0);
    req_i = 4'b0000;
    repeat (64) @(negedge clk);
    cu_done = 1'b1;
    @(negedge clk);
    cu_done = 1'b0;
    check("race_done", 32'(done_o), 32'b0001);
    check("race_no_timeout", 32'(timeout_o), 32'd0);
    @(negedge clk);

    // Reset during WAIT abandons the transaction silently
    do_reset();
    req_i      = 4'b1111;
    req_type_i = T_A;
    wait_issue();
    check("rst_seq_first", 32'(cu_unit_id), 32'd0);
    push_done(4'b0001, 1'b0);
    finish_txn();
    wait_issue();
    check("rst_seq_second", 32'(cu_unit_id), 32'd1);
    push_done(4'b0010, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    done_q.delete();
    @(negedge clk);
    check_quiet("reset_mid_wait");
    @(negedge clk);
    req_i = 4'b0110;
    rst_n = 1'b1;
    wait_issue();
    check("post_rst_grant", 32'(grant_o), 32'b0010);
    check("post_rst_unit_id", 32'(cu_unit_id), 32'd1);
    push_done(4'b0010, 1'b0);
    req_i = 4'b0000;
    finish_txn();
    repeat (3) @(negedge clk);
    check("final_done_drained", 32'(done_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
